// File: rtl/pulse_mixer_uart_if.sv
// Signal bundle of the pulse-rate reporter: measurement inputs and UART/status outputs.
// The master side drives en/pulse; the slave side is the measuring block itself.
interface pulse_mixer_uart_if #(
  parameter int CNT_W = 16
);
  logic             en_i;
  logic             pulse_i;
  logic             uart_tx_o;
  logic             uart_pulse_o;
  logic [CNT_W-1:0] count_o;
  logic             overrun_o;

  modport master (
    output en_i, pulse_i,
    input  uart_tx_o, uart_pulse_o, count_o, overrun_o
  );

  modport slave (
    input  en_i, pulse_i,
    output uart_tx_o, uart_pulse_o, count_o, overrun_o
  );
endinterface

// File: rtl/pulse_mixer_uart.sv
// Counts rising edges of an asynchronous pulse input over a fixed window and reports each
// window's count as a 7-character ASCII frame ("C" + 4 hex digits + CR LF) on a UART 8N1 line.
module pulse_mixer_uart #(
  parameter int CLKS_PER_BIT  = 347,
  parameter int WINDOW_CYCLES = 40000,
  parameter int CNT_W         = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  pulse_mixer_uart_if.slave bus
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int CLK_W = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] frame_char(input logic [2:0] idx, input logic [15:0] v);
    logic [7:0] ch;
    case (idx)
      3'd0:    ch = 8'h43;
      3'd1:    ch = hex_char(v[15:12]);
      3'd2:    ch = hex_char(v[11:8]);
      3'd3:    ch = hex_char(v[7:4]);
      3'd4:    ch = hex_char(v[3:0]);
      3'd5:    ch = 8'h0D;
      default: ch = 8'h0A;
    endcase
    return ch;
  endfunction

  logic             sync1_q, sync2_q, prev_q;
  logic             edge_det;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] run_q, run_next, count_q;
  logic             overrun_q;
  logic             terminal, frame_go;

  tx_state_e        state_q, state_d;
  logic [CLK_W-1:0] clk_q, clk_d;
  logic [2:0]       bit_q, bit_d, char_q, char_d;
  logic [15:0]      snap_q, snap_d, count_ext;
  logic [7:0]       ch_d;
  logic             last_clk, tx_q, tx_d, pulse_q, pulse_d;

  // Two synchronizer stages, then a third flop that remembers the previous level.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1_q <= bus.pulse_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_det = sync2_q & ~prev_q;
  assign run_next = (run_q == '1) ? run_q : run_q + CNT_W'(edge_det);
  assign terminal = bus.en_i && (win_q == WIN_W'(WINDOW_CYCLES - 1));
  assign frame_go = terminal && (state_q == IDLE);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      win_q     <= '0;
      run_q     <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else if (!bus.en_i) begin
      win_q <= '0;
      run_q <= '0;
    end else if (terminal) begin
      count_q <= run_next;
      run_q   <= '0;
      win_q   <= '0;
      if (state_q != IDLE) overrun_q <= 1'b1;
    end else begin
      win_q <= win_q + 1'b1;
      run_q <= run_next;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      clk_q   <= '0;
      bit_q   <= '0;
      char_q  <= '0;
      snap_q  <= '0;
      tx_q    <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      snap_q  <= snap_d;
      tx_q    <= tx_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d   = state_q;
    clk_d     = clk_q;
    bit_d     = bit_q;
    char_d    = char_q;
    snap_d    = snap_q;
    count_ext = '0;
    count_ext[CNT_W-1:0] = run_next;
    last_clk  = (clk_q == CLK_W'(CLKS_PER_BIT - 1));
    case (state_q)
      IDLE: if (frame_go) begin
        state_d = START;
        clk_d   = '0;
        char_d  = '0;
        snap_d  = count_ext;
      end
      START: if (last_clk) begin
        clk_d   = '0;
        bit_d   = '0;
        state_d = DATA;
      end else clk_d = clk_q + 1'b1;
      DATA: if (last_clk) begin
        clk_d = '0;
        if (bit_q == 3'd7) state_d = STOP;
        else               bit_d   = bit_q + 1'b1;
      end else clk_d = clk_q + 1'b1;
      STOP: if (last_clk) begin
        clk_d = '0;
        if (char_q == 3'd6) state_d = IDLE;
        else begin
          char_d  = char_q + 1'b1;
          state_d = START;
        end
      end else clk_d = clk_q + 1'b1;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so the line never glitches.
    ch_d = frame_char(char_d, snap_d);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = ch_d[bit_d];
      default: tx_d = 1'b1;
    endcase
    pulse_d = (state_d != IDLE);
  end

  assign bus.uart_tx_o    = tx_q;
  assign bus.uart_pulse_o = pulse_q;
  assign bus.count_o      = count_q;
  assign bus.overrun_o    = overrun_q;

endmodule

// File: tb/tb_pulse_mixer_uart.sv
// Randomized bench for pulse_mixer_uart: a window-level reference model predicts counts and
// frame start times; a separate monitor decodes the UART line and checks it against the queue.
module tb_pulse_mixer_uart;

  localparam int CPB   = 4;
  localparam int WIN   = 200;
  localparam int CW    = 6;
  localparam int FRAME = 70 * CPB;
  localparam int MAXC  = (1 << CW) - 1;

  typedef struct {
    int value;
    int start;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pulse_mixer_uart_if #(.CNT_W(CW)) bus ();

  pulse_mixer_uart #(
    .CLKS_PER_BIT (CPB),
    .WINDOW_CYCLES(WIN),
    .CNT_W        (CW)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: per clock edge, an input rise becomes countable two edges later.
  frame_t exp_q[$];
  int     cyc = 0;
  int     m_win = 0, m_run = 0, m_cnt = 0, m_busy_end = -1;
  bit     m_ovr = 1'b0;
  bit     h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;

  always @(posedge clk) begin
    bit e;
    cyc++;
    if (rst) begin
      m_win = 0; m_run = 0; m_cnt = 0; m_ovr = 1'b0;
      m_busy_end = cyc;
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
      exp_q.delete();
    end else begin
      e  = h1 & ~h2;
      h2 = h1; h1 = h0; h0 = bus.pulse_i;
      if (!bus.en_i) begin
        m_win = 0;
        m_run = 0;
      end else if (m_win == WIN - 1) begin
        m_cnt = (m_run + e > MAXC) ? MAXC : m_run + e;
        m_run = 0;
        m_win = 0;
        if (cyc > m_busy_end) begin
          exp_q.push_back('{value: m_cnt, start: cyc});
          m_busy_end = cyc + FRAME;
        end else m_ovr = 1'b1;
      end else begin
        m_win++;
        m_run = (m_run + e > MAXC) ? MAXC : m_run + e;
      end
    end
  end

  function automatic logic [7:0] exp_char(input int v, input int k);
    int n;
    case (k)
      0: return 8'h43;
      5: return 8'h0D;
      6: return 8'h0A;
      default: begin
        n = (v >> (4 * (4 - k))) & 15;
        return (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
      end
    endcase
  endfunction

  // Monitor: decodes frames from the line, checks framing, timing and content.
  bit in_frame = 1'b0;

  initial begin
    bit         prev_pulse = 1'b0;
    int         fstart = 0, fval = 0, off;
    logic [69:0] rx;
    logic [9:0]  got10, exp10;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame   = 1'b0;
        prev_pulse = 1'b0;
        continue;
      end
      if (cyc % 8 == 0) begin
        check("count_o", int'(bus.count_o), m_cnt);
        check("overrun_o", int'(bus.overrun_o), int'(m_ovr));
      end
      if (!in_frame) begin
        if (bus.uart_pulse_o && !prev_pulse) begin
          check("rise_with_start_bit", int'(bus.uart_tx_o), 0);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            fval = -1;
          end else begin
            frame_t f;
            f = exp_q.pop_front();
            check("frame_start_cycle", cyc, f.start);
            fval = f.value;
          end
          fstart   = cyc;
          in_frame = 1'b1;
          rx       = '1;
          rx[0]    = bus.uart_tx_o;
        end else if (exp_q.size() != 0 && exp_q[0].start < cyc) begin
          check("missing_frame_at", cyc, exp_q[0].start);
          void'(exp_q.pop_front());
        end
      end else begin
        off = cyc - fstart;
        if (off < FRAME && off % CPB == CPB / 2) rx[off / CPB] = bus.uart_tx_o;
        if (off == FRAME - 1) check("pulse_high_last_bit", int'(bus.uart_pulse_o), 1);
        if (off == FRAME) begin
          check("pulse_low_after_frame", int'(bus.uart_pulse_o), 0);
          if (fval >= 0) begin
            for (int c = 0; c < 7; c++) begin
              for (int k = 0; k < 10; k++) got10[k] = rx[c * 10 + k];
              exp10 = {1'b1, exp_char(fval, c), 1'b0};
              check($sformatf("frame%0d_char%0d", fval, c), int'(got10), int'(exp10));
            end
          end
          in_frame = 1'b0;
        end
      end
      prev_pulse = bus.uart_pulse_o;
    end
  end

  task automatic run_phase(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (mode)
        0: bus.pulse_i = 1'b0;
        1: bus.pulse_i = (i % 8) < 4;
        2: if ($urandom_range(0, 5) == 0) bus.pulse_i = ~bus.pulse_i;
        3: bus.pulse_i = ~bus.pulse_i;
        4: bus.pulse_i = 1'($urandom_range(0, 1));
        default: bus.pulse_i = 1'b1;
      endcase
    end
  endtask

  task automatic wait_frame(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 4 * WIN && !found; i++) begin
      @(negedge clk);
      found = bus.uart_pulse_o;
    end
    check(name, int'(found), 1);
  endtask

  initial begin
    bit drained;
    bus.en_i    = 1'b0;
    bus.pulse_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_tx", int'(bus.uart_tx_o), 1);
    check("reset_pulse", int'(bus.uart_pulse_o), 0);
    check("reset_count", int'(bus.count_o), 0);
    check("reset_overrun", int'(bus.overrun_o), 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    bus.en_i = 1'b1;

    run_phase(0, 5 * WIN);
    check("const_low_count", int'(bus.count_o), 0);
    check("overrun_when_frame_outlasts_window", int'(bus.overrun_o), 1);
    run_phase(1, 5 * WIN);
    check("square_wave_count", int'(bus.count_o), 25);
    run_phase(5, 5 * WIN);
    check("const_high_count", int'(bus.count_o), 0);
    run_phase(3, 5 * WIN);
    check("saturated_count", int'(bus.count_o), MAXC);
    run_phase(2, 10 * WIN);
    run_phase(4, 5 * WIN);

    // Disable mid-frame: the frame in flight finishes, nothing new starts, count holds.
    wait_frame("frame_before_disable");
    repeat (20) @(negedge clk);
    bus.en_i = 1'b0;
    run_phase(4, 5 * WIN);
    bus.en_i = 1'b1;
    run_phase(2, 3 * WIN);

    // Reset during a data bit: line idles and pulse drops without waiting for a clock.
    wait_frame("frame_before_reset");
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midframe_reset_tx", int'(bus.uart_tx_o), 1);
    check("midframe_reset_pulse", int'(bus.uart_pulse_o), 0);
    check("midframe_reset_count", int'(bus.count_o), 0);
    check("midframe_reset_overrun", int'(bus.overrun_o), 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    run_phase(1, 8 * WIN);
    check("square_wave_count_after_reset", int'(bus.count_o), 25);

    bus.en_i    = 1'b0;
    bus.pulse_i = 1'b0;
    drained = 1'b0;
    for (int i = 0; i < 4 * FRAME && !drained; i++) begin
      @(negedge clk);
      drained = (exp_q.size() == 0) && !in_frame;
    end
    check("drain_expected_frames", int'(drained), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
